// File: rtl/bp_cfg_link_pkg.sv
// bp_cfg_link_pkg: shared types and register map for the cfg-link boot loader
//   bp_cfg_loader_state_e  loader FSM states
//   bp_cce_mode_e          CCE mode values (uncached=0, normal=1)
//   bp_cfg_link_pkt_s      one cfg-link beat {addr, data}
package bp_cfg_link_pkg;

  localparam logic [15:0] cfg_reg_reset_gp       = 16'h0001;
  localparam logic [15:0] cfg_reg_freeze_gp      = 16'h0002;
  localparam logic [15:0] cfg_reg_icache_mode_gp = 16'h0022;
  localparam logic [15:0] cfg_reg_pc_lo_gp       = 16'h0040;
  localparam logic [15:0] cfg_reg_pc_hi_gp       = 16'h0041;
  localparam logic [15:0] cfg_reg_dcache_mode_gp = 16'h0042;
  localparam logic [15:0] cfg_reg_cce_mode_gp    = 16'h0060;
  localparam logic [15:0] cfg_reg_num_lce_gp     = 16'h0061;
  localparam logic [15:0] cfg_reg_cce_ucode_gp   = 16'h8000;

  typedef enum logic [3:0] {
    E_IDLE, E_FREEZE, E_RST, E_PC_LO, E_PC_HI, E_IMODE, E_DMODE, E_NLCE,
    E_CCE_UC, E_UC_RD, E_UC_WR, E_VFY_RD, E_VFY_WAIT, E_CCE_NORM, E_UNFREEZE, E_DONE
  } bp_cfg_loader_state_e;

  typedef enum logic {
    E_CCE_UNCACHED = 1'b0,
    E_CCE_NORMAL   = 1'b1
  } bp_cce_mode_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } bp_cfg_link_pkt_s;

  // States that hold cfg_w_v_o high until the slave accepts the beat.
  function automatic logic is_write(bp_cfg_loader_state_e s);
    return !(s inside {E_IDLE, E_UC_RD, E_VFY_RD, E_VFY_WAIT, E_DONE});
  endfunction

endpackage

// File: rtl/bp_cfg_link_loader.sv
// bp_cfg_link_loader: cfg-link initiator that writes the tile boot sequence after start_i
//   clk_i, reset_n_i (async, active-low), start_i + start_pc_i/icache_mode_i/dcache_mode_i
//   ucode_v_o/ucode_addr_o -> ROM, ucode_data_i valid the cycle after the strobe
//   cfg_w_v_o/cfg_addr_o/cfg_data_o/cfg_ready_i cfg write link; busy_o, done_o status
//   BP_CFG_LOADER_VERIFY_EN adds cfg_r_v_o, cfg_rdata_v_i, cfg_rdata_i, error_o (ucode readback)
module bp_cfg_link_loader
  import bp_cfg_link_pkg::*;
#(
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 32,
  parameter int vaddr_width_p    = 64,
  parameter int ucode_els_p      = 256,
  parameter int num_lce_p        = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  input  logic [vaddr_width_p-1:0]    start_pc_i,
  input  logic [31:0]                 icache_mode_i,
  input  logic [31:0]                 dcache_mode_i,
  output logic                        ucode_v_o,
  output logic [11:0]                 ucode_addr_o,
  input  logic [31:0]                 ucode_data_i,
  output logic                        cfg_w_v_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ready_i,
  output logic                        busy_o,
  output logic                        done_o
`ifdef BP_CFG_LOADER_VERIFY_EN
  ,
  output logic                        cfg_r_v_o,
  input  logic                        cfg_rdata_v_i,
  input  logic [31:0]                 cfg_rdata_i,
  output logic                        error_o
`endif
);

  bp_cfg_loader_state_e state, state_n, nxt;
  bp_cfg_link_pkt_s pkt;
  logic [vaddr_width_p-1:0] pc_q;
  logic [31:0] im_q, dm_q, uc_q, uc_d;
  logic [11:0] idx;
  logic fresh, adv_idx, last;

  assign last = idx == 12'(ucode_els_p - 1);
  // First UC_WR cycle forwards the ROM word; later (stalled) cycles use the held copy.
  assign uc_d = fresh ? ucode_data_i : uc_q;

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state <= E_IDLE;
      idx   <= '0;
      pc_q  <= '0;
      im_q  <= '0;
      dm_q  <= '0;
      uc_q  <= '0;
      fresh <= 1'b0;
    end else begin
      state <= state_n;
      fresh <= state == E_UC_RD;
      if (fresh) uc_q <= ucode_data_i;
      if (adv_idx) idx <= idx + 12'd1;
      if (state == E_IDLE && start_i) begin
        pc_q <= start_pc_i;
        im_q <= icache_mode_i;
        dm_q <= dcache_mode_i;
      end
    end

`ifdef BP_CFG_LOADER_VERIFY_EN
  logic err_q;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) err_q <= 1'b0;
    else if (state == E_VFY_WAIT && cfg_rdata_v_i && cfg_rdata_i != uc_q) err_q <= 1'b1;
  assign error_o   = err_q;
  assign cfg_r_v_o = state == E_VFY_RD;
`endif

  always_comb begin
    state_n      = state;
    nxt          = state;
    pkt          = '0;
    ucode_v_o    = 1'b0;
    ucode_addr_o = '0;
    adv_idx      = 1'b0;
    case (state)
      E_IDLE:     state_n = start_i ? E_FREEZE : E_IDLE;
      E_FREEZE:   begin pkt = '{cfg_reg_freeze_gp, 32'd1}; nxt = E_RST; end
      E_RST:      begin pkt = '{cfg_reg_reset_gp, 32'd0}; nxt = E_PC_LO; end
      E_PC_LO:    begin pkt = '{cfg_reg_pc_lo_gp, pc_q[31:0]}; nxt = E_PC_HI; end
      E_PC_HI:    begin pkt = '{cfg_reg_pc_hi_gp, 32'(pc_q >> 32)}; nxt = E_IMODE; end
      E_IMODE:    begin pkt = '{cfg_reg_icache_mode_gp, im_q}; nxt = E_DMODE; end
      E_DMODE:    begin pkt = '{cfg_reg_dcache_mode_gp, dm_q}; nxt = E_NLCE; end
      E_NLCE:     begin pkt = '{cfg_reg_num_lce_gp, 32'(num_lce_p)}; nxt = E_CCE_UC; end
      E_CCE_UC:   begin pkt = '{cfg_reg_cce_mode_gp, 32'(E_CCE_UNCACHED)}; nxt = E_UC_RD; end
      E_UC_RD:    begin ucode_v_o = 1'b1; ucode_addr_o = idx; state_n = E_UC_WR; end
      E_UC_WR: begin
        pkt = '{cfg_reg_cce_ucode_gp | 16'(idx), uc_d};
`ifdef BP_CFG_LOADER_VERIFY_EN
        nxt = E_VFY_RD;
`else
        nxt     = last ? E_CCE_NORM : E_UC_RD;
        adv_idx = cfg_ready_i;
`endif
      end
`ifdef BP_CFG_LOADER_VERIFY_EN
      E_VFY_RD: begin
        pkt.addr = cfg_reg_cce_ucode_gp | 16'(idx);
        state_n  = cfg_ready_i ? E_VFY_WAIT : E_VFY_RD;
      end
      E_VFY_WAIT: begin
        adv_idx = cfg_rdata_v_i;
        state_n = !cfg_rdata_v_i ? E_VFY_WAIT : last ? E_CCE_NORM : E_UC_RD;
      end
`endif
      E_CCE_NORM: begin pkt = '{cfg_reg_cce_mode_gp, 32'(E_CCE_NORMAL)}; nxt = E_UNFREEZE; end
      E_UNFREEZE: begin pkt = '{cfg_reg_freeze_gp, 32'd0}; nxt = E_DONE; end
      default: ;
    endcase
    if (is_write(state) && cfg_ready_i) state_n = nxt;
  end

  assign cfg_w_v_o  = is_write(state);
  assign cfg_addr_o = cfg_addr_width_p'(pkt.addr);
  assign cfg_data_o = cfg_data_width_p'(pkt.data);
  assign busy_o     = !(state inside {E_IDLE, E_DONE});
  assign done_o     = state == E_DONE;

endmodule

// File: tb/tb_bp_cfg_link_loader.sv
// tb_bp_cfg_link_loader: randomized self-checking bench for bp_cfg_link_loader
module tb_bp_cfg_link_loader;

  localparam int ELS = 4;

  logic        clk, reset_n_i, start_i, cfg_ready_i;
  logic [63:0] start_pc_i;
  logic [31:0] icache_mode_i, dcache_mode_i, ucode_data_i;
  logic        ucode_v_o, cfg_w_v_o, busy_o, done_o;
  logic [11:0] ucode_addr_o;
  logic [15:0] cfg_addr_o;
  logic [31:0] cfg_data_o;

  int passed = 0, total = 0;
  int stab_err = 0, done_early = 0;
  bit stall_en = 0;
  logic [47:0] got[$], exp_q[$];

`ifdef BP_CFG_LOADER_VERIFY_EN
  logic        cfg_r_v_o, cfg_rdata_v_i, error_o;
  logic [31:0] cfg_rdata_i;
  logic [31:0] wmem [logic [15:0]];
  bit          corrupt = 0;
`endif

  bp_cfg_link_loader #(.ucode_els_p(ELS)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i), .start_pc_i(start_pc_i),
    .icache_mode_i(icache_mode_i), .dcache_mode_i(dcache_mode_i),
    .ucode_v_o(ucode_v_o), .ucode_addr_o(ucode_addr_o), .ucode_data_i(ucode_data_i),
    .cfg_w_v_o(cfg_w_v_o), .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o),
    .cfg_ready_i(cfg_ready_i), .busy_o(busy_o), .done_o(done_o)
`ifdef BP_CFG_LOADER_VERIFY_EN
    , .cfg_r_v_o(cfg_r_v_o), .cfg_rdata_v_i(cfg_rdata_v_i), .cfg_rdata_i(cfg_rdata_i),
    .error_o(error_o)
`endif
  );

  initial begin clk = 0; forever #5 clk = ~clk; end

  // Slave ready: either always ready or random 0-5 cycle stalls between accepts.
  initial begin
    int cnt = 0;
    cfg_ready_i = 1;
    forever begin
      @(posedge clk); #1;
      if (!stall_en) cfg_ready_i = 1;
      else if (cnt == 0) begin cfg_ready_i = 1; cnt = $urandom_range(0, 5); end
      else begin cfg_ready_i = 0; cnt--; end
    end
  end

  // ROM: word idx*3 only in the cycle after the strobe, junk otherwise.
  initial begin
    logic rv;
    logic [11:0] ra;
    ucode_data_i = 0;
    forever begin
      @(negedge clk); rv = ucode_v_o; ra = ucode_addr_o;
      @(posedge clk); #1 ucode_data_i = rv ? 32'(ra) * 3 : $urandom;
    end
  end

  // Monitor: logs accepted writes, tracks stall stability and early done.
  initial begin
    bit ps = 0;
    logic [15:0] pa;
    logic [31:0] pd;
    forever begin
      @(negedge clk);
      if (!reset_n_i) ps = 0;
      else begin
        if (ps && !(cfg_w_v_o && cfg_addr_o == pa && cfg_data_o == pd)) stab_err++;
        if (cfg_w_v_o && cfg_ready_i) begin
          got.push_back({cfg_addr_o, cfg_data_o});
          if (done_o) done_early++;
`ifdef BP_CFG_LOADER_VERIFY_EN
          wmem[cfg_addr_o] = cfg_data_o;
`endif
        end
        ps = cfg_w_v_o && !cfg_ready_i;
        pa = cfg_addr_o;
        pd = cfg_data_o;
      end
    end
  end

`ifdef BP_CFG_LOADER_VERIFY_EN
  initial begin
    logic [15:0] a;
    cfg_rdata_v_i = 0; cfg_rdata_i = 0;
    forever begin
      @(negedge clk);
      if (reset_n_i && cfg_r_v_o && cfg_ready_i) begin
        a = cfg_addr_o;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 cfg_rdata_v_i = 1;
        cfg_rdata_i = wmem[a] ^ ((corrupt && a == 16'h8001) ? 32'h1 : 32'h0);
        @(posedge clk); #1 cfg_rdata_v_i = 0;
      end
    end
  end
`endif

  // Reference: the boot write list derived directly from the register map.
  function automatic void build_exp(input logic [63:0] pc, input logic [31:0] im, dm);
    exp_q.delete();
    exp_q.push_back({16'h0002, 32'd1});
    exp_q.push_back({16'h0001, 32'd0});
    exp_q.push_back({16'h0040, pc[31:0]});
    exp_q.push_back({16'h0041, pc[63:32]});
    exp_q.push_back({16'h0022, im});
    exp_q.push_back({16'h0042, dm});
    exp_q.push_back({16'h0061, 32'd2});
    exp_q.push_back({16'h0060, 32'd0});
    for (int i = 0; i < ELS; i++) exp_q.push_back({16'h8000 + 16'(i), 32'(i * 3)});
    exp_q.push_back({16'h0060, 32'd1});
    exp_q.push_back({16'h0002, 32'd0});
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n_i = 0; start_i = 0;
    repeat (3) @(negedge clk);
    got.delete(); stab_err = 0; done_early = 0;
    reset_n_i = 1;
  endtask

  // Pulses start and waits for done; optionally fires extra starts while busy.
  task automatic run_seq(input logic [63:0] pc, input logic [31:0] im, dm,
                         input bit noise, output int cyc);
    @(negedge clk);
    start_i = 1; start_pc_i = pc; icache_mode_i = im; dcache_mode_i = dm;
    @(posedge clk); #1 start_i = 0;
    cyc = 0;
    do begin
      @(posedge clk); cyc++; #1;
      if (noise) begin
        start_i = (cyc % 5 == 2);
        start_pc_i = {$urandom, $urandom};
        icache_mode_i = $urandom;
      end
    end while (!done_o && cyc < 2000);
    start_i = 0;
  endtask

  task automatic test_reset();
    reset_n_i = 0; start_i = 0; start_pc_i = 0; icache_mode_i = 0; dcache_mode_i = 0;
    repeat (2) @(negedge clk);
    total++; if (cfg_w_v_o !== 0) $display("FAIL reset_wv got=%b exp=0", cfg_w_v_o); else passed++;
    total++; if (cfg_addr_o !== 0) $display("FAIL reset_addr got=%h exp=0", cfg_addr_o); else passed++;
    total++; if (cfg_data_o !== 0) $display("FAIL reset_data got=%h exp=0", cfg_data_o); else passed++;
    total++; if ({ucode_v_o, ucode_addr_o} !== 0) $display("FAIL reset_ucode got=%h exp=0", {ucode_v_o, ucode_addr_o}); else passed++;
    total++; if ({busy_o, done_o} !== 0) $display("FAIL reset_status got=%b exp=00", {busy_o, done_o}); else passed++;
  endtask

  task automatic test_basic();
    int cyc;
    logic [31:0] im = $urandom, dm = $urandom;
    do_reset();
    stall_en = 0;
    build_exp(64'h0000_0080_8000_0000, im, dm);
    run_seq(64'h0000_0080_8000_0000, im, dm, 0, cyc);
    total++; if (got.size() !== 14) $display("FAIL basic_count got=%0d exp=14", got.size()); else passed++;
    for (int i = 0; i < 14 && i < got.size(); i++) begin
      total++; if (got[i] !== exp_q[i]) $display("FAIL basic_w%0d got=%h exp=%h", i, got[i], exp_q[i]); else passed++;
    end
    total++; if (got.size() > 3 && got[2][31:0] !== 32'h8000_0000) $display("FAIL pc_lo got=%h exp=80000000", got[2][31:0]); else passed++;
    total++; if (got.size() > 3 && got[3][31:0] !== 32'h0000_0080) $display("FAIL pc_hi got=%h exp=00000080", got[3][31:0]); else passed++;
    total++; if (done_o !== 1 || busy_o !== 0) $display("FAIL basic_done got=%b%b exp=10", done_o, busy_o); else passed++;
    total++; if (done_early !== 0) $display("FAIL done_early got=%0d exp=0", done_early); else passed++;
`ifndef BP_CFG_LOADER_VERIFY_EN
    total++; if (cyc !== 10 + 2 * ELS) $display("FAIL basic_cycles got=%0d exp=%0d", cyc, 10 + 2 * ELS); else passed++;
`else
    total++; if (error_o !== 0) $display("FAIL basic_error got=%b exp=0", error_o); else passed++;
`endif
  endtask

  task automatic test_stall();
    int cyc;
    logic [63:0] pc = {$urandom, $urandom};
    logic [31:0] im = $urandom, dm = $urandom;
    do_reset();
    stall_en = 1;
    build_exp(pc, im, dm);
    run_seq(pc, im, dm, 0, cyc);
    stall_en = 0;
    total++; if (cyc >= 2000) $display("FAIL stall_timeout got=%0d exp<2000", cyc); else passed++;
    total++; if (got !== exp_q) $display("FAIL stall_seq got_n=%0d exp_n=%0d", got.size(), exp_q.size()); else passed++;
    total++; if (stab_err !== 0) $display("FAIL stall_stable got=%0d exp=0", stab_err); else passed++;
  endtask

  task automatic test_ucode_data();
    int cyc;
    do_reset();
    stall_en = 1;
    run_seq({$urandom, $urandom}, $urandom, $urandom, 0, cyc);
    stall_en = 0;
    for (int i = 0; i < ELS; i++) begin
      logic [47:0] e = {16'h8000 + 16'(i), 32'(i * 3)};
      total++; if (got.size() < 14 || got[8 + i] !== e) $display("FAIL ucode_w%0d got=%h exp=%h", i, got.size() >= 14 ? got[8 + i] : 48'h0, e); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    logic [63:0] pc = {$urandom, $urandom};
    logic [31:0] im = $urandom, dm = $urandom;
    do_reset();
    stall_en = 0;
    @(negedge clk);
    start_i = 1; start_pc_i = pc; icache_mode_i = im; dcache_mode_i = dm;
    @(posedge clk); #1 start_i = 0;
    do begin @(negedge clk); cyc++; end while (!(cfg_w_v_o && cfg_addr_o == 16'h8002) && cyc < 200);
    total++; if (cyc >= 200) $display("FAIL rmid_reach got=%0d exp<200", cyc); else passed++;
    #2 reset_n_i = 0;
    #1;
    total++; if ({cfg_w_v_o, cfg_addr_o, cfg_data_o, ucode_v_o, ucode_addr_o, busy_o, done_o} !== 0)
      $display("FAIL rmid_outs got=%b%h%h exp=0", cfg_w_v_o, cfg_addr_o, cfg_data_o); else passed++;
    do_reset();
    build_exp(pc, im, dm);
    run_seq(pc, im, dm, 0, cyc);
    total++; if (got !== exp_q) $display("FAIL rmid_restart got_n=%0d exp_n=%0d", got.size(), exp_q.size()); else passed++;
  endtask

  task automatic test_start_ignored();
    int cyc;
    logic [63:0] pc = {$urandom, $urandom};
    logic [31:0] im = $urandom, dm = $urandom;
    do_reset();
    stall_en = 1;
    build_exp(pc, im, dm);
    run_seq(pc, im, dm, 1, cyc);
    total++; if (got !== exp_q) $display("FAIL busy_start_seq got_n=%0d exp_n=%0d", got.size(), exp_q.size()); else passed++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); start_i = (i % 4 == 0); start_pc_i = {$urandom, $urandom};
    end
    start_i = 0;
    @(negedge clk);
    stall_en = 0;
    total++; if (got.size() !== 14) $display("FAIL done_start_count got=%0d exp=14", got.size()); else passed++;
    total++; if ({done_o, busy_o, cfg_w_v_o} !== 3'b100) $display("FAIL done_start_status got=%b exp=100", {done_o, busy_o, cfg_w_v_o}); else passed++;
  endtask

`ifdef BP_CFG_LOADER_VERIFY_EN
  task automatic test_verify_error();
    int cyc;
    logic [63:0] pc = {$urandom, $urandom};
    logic [31:0] im = $urandom, dm = $urandom;
    do_reset();
    corrupt = 1;
    build_exp(pc, im, dm);
    run_seq(pc, im, dm, 0, cyc);
    corrupt = 0;
    total++; if (error_o !== 1) $display("FAIL verify_error got=%b exp=1", error_o); else passed++;
    total++; if (got !== exp_q || done_o !== 1) $display("FAIL verify_seq got_n=%0d exp_n=%0d", got.size(), exp_q.size()); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_ucode_data();
    test_reset_mid();
    test_start_ignored();
`ifdef BP_CFG_LOADER_VERIFY_EN
    test_verify_error();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
